// File: rtl/vga_axil_regfile.sv
// vga_axil_regfile: AXI4-Lite register bank for the VGA core.
// Register contents are exposed flat on regs_o for the video datapath.
module vga_axil_regfile #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 4
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [ADDR_W-1:0]         awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDR_W-1:0]         araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_W-1:0]         rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [REG_NUM*DATA_W-1:0] regs_o
);

  localparam int IDX_W  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(REG_NUM * 4);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic                alive_q;
  logic                aw_held_q, aw_held_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic                w_held_q, w_held_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [STRB_W-1:0]   w_strb_q, w_strb_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   regs_q [REG_NUM];
  logic [DATA_W-1:0]   regs_d [REG_NUM];

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, commit;
  logic wr_ok, rd_ok;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  function automatic logic dec_ok(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && (a < LIMIT);
  endfunction

  function automatic logic [IDX_W-1:0] dec_idx(input logic [ADDR_W-1:0] a);
    return a[2 +: IDX_W];
  endfunction

  // Readies come only from flops, so no valid->ready path exists.
  assign awready = alive_q & ~aw_held_q & ~bvalid_q;
  assign wready  = alive_q & ~w_held_q & ~bvalid_q;
  assign arready = alive_q & ~rvalid_q;

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign ar_hs  = arvalid & arready;
  assign b_hs   = bvalid_q & bready;
  assign r_hs   = rvalid_q & rready;
  assign commit = aw_held_q & w_held_q;

  assign wr_ok  = dec_ok(aw_addr_q);
  assign wr_idx = dec_idx(aw_addr_q);
  assign rd_ok  = dec_ok(araddr);
  assign rd_idx = dec_idx(araddr);

  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? OKAY : SLVERR;
      if (wr_ok) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (w_strb_q[b]) regs_d[wr_idx][8*b +: 8] = w_data_q[8*b +: 8];
        end
      end
    end else if (b_hs) begin
      bvalid_d = 1'b0;
    end
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end
  end

  // Reads sample regs_q, so a same-cycle commit is not yet visible.
  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_ok ? OKAY : SLVERR;
      rdata_d  = rd_ok ? regs_q[rd_idx] : '0;
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      alive_q   <= 1'b0;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else begin
      alive_q   <= 1'b1;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign rvalid = rvalid_q;
  assign rresp  = rresp_q;
  assign rdata  = rdata_q;

  for (genvar g = 0; g < REG_NUM; g++) begin : g_out
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_vga_axil_regfile.sv
// tb_vga_axil_regfile: random + directed AXI-Lite traffic against a
// cycle-level reference model of the register bank.
module tb_vga_axil_regfile;

  localparam int RN = 4;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic [31:0]   awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [31:0]   araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [127:0]  regs_o;

  int checks = 0;
  int failures = 0;

  vga_axil_regfile #(.ADDR_W(32), .DATA_W(32), .REG_NUM(RN)) dut (
    .clk(clk), .arst_n(arst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level view of the bank.
  logic [31:0] m_regs [RN];
  bit          m_alive, m_awh, m_wh, m_bv, m_rv;
  logic [31:0] m_awa, m_wd, m_rd;
  logic [3:0]  m_ws;
  logic [1:0]  m_br, m_rr;

  function automatic bit ok_addr(input logic [31:0] a);
    return (a % 4 == 0) && (a < RN * 4);
  endfunction

  task automatic m_reset();
    m_alive = 0; m_awh = 0; m_wh = 0; m_bv = 0; m_rv = 0;
    m_br = 0; m_rr = 0; m_rd = 0;
    for (int i = 0; i < RN; i++) m_regs[i] = 0;
  endtask

  task automatic m_step();
    bit awr, wr, arr, cm;
    logic [31:0] mask;
    awr = m_alive && !m_awh && !m_bv;
    wr  = m_alive && !m_wh && !m_bv;
    arr = m_alive && !m_rv;
    cm  = m_awh && m_wh;
    if (arvalid && arr) begin
      m_rv = 1;
      if (ok_addr(araddr)) begin
        m_rr = 0; m_rd = m_regs[araddr / 4];
      end else begin
        m_rr = 2; m_rd = 0;
      end
    end else if (m_rv && rready) begin
      m_rv = 0;
    end
    if (m_bv && bready) m_bv = 0;
    if (cm) begin
      m_awh = 0; m_wh = 0; m_bv = 1;
      if (ok_addr(m_awa)) begin
        m_br = 0;
        mask = 0;
        for (int b = 0; b < 4; b++) if (m_ws[b]) mask |= 32'hFF << (8 * b);
        m_regs[m_awa / 4] = (m_regs[m_awa / 4] & ~mask) | (m_wd & mask);
      end else begin
        m_br = 2;
      end
    end
    if (awvalid && awr) begin m_awh = 1; m_awa = awaddr; end
    if (wvalid && wr) begin m_wh = 1; m_wd = wdata; m_ws = wstrb; end
    m_alive = 1;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge arst_n);
      if (!arst_n) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("awready", awready, m_alive && !m_awh && !m_bv);
      chk("wready", wready, m_alive && !m_wh && !m_bv);
      chk("arready", arready, m_alive && !m_rv);
      chk("bvalid", bvalid, m_bv);
      chk("rvalid", rvalid, m_rv);
      chk("regs_o", regs_o, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
      if (m_bv) chk("bresp", bresp, m_br);
      if (m_rv) begin
        chk("rresp", rresp, m_rr);
        chk("rdata", rdata, m_rd);
      end
    end
  end

  task automatic send_aw(input logic [31:0] a, input int dly);
    int n = 0;
    repeat (dly) @(posedge clk);
    #1;
    awaddr = a; awvalid = 1'b1;
    while (!awready && n < 64) begin @(negedge clk); n++; end
    chk("aw_timeout", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s,
                        input int dly);
    int n = 0;
    repeat (dly) @(posedge clk);
    #1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!wready && n < 64) begin @(negedge clk); n++; end
    chk("w_timeout", wready, 1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int awd, input int wd,
                          input int bd, output logic [1:0] resp);
    int n = 0;
    fork
      send_aw(a, awd);
      send_w(d, s, wd);
    join
    while (!bvalid && n < 16) begin @(negedge clk); n++; end
    chk("b_timeout", bvalid, 1);
    resp = bresp;
    repeat (bd) @(negedge clk);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int rd,
                         output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 64) begin @(negedge clk); n++; end
    chk("ar_timeout", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 16) begin @(negedge clk); n++; end
    chk("r_timeout", rvalid, 1);
    data = rdata; resp = rresp;
    repeat (rd) @(negedge clk);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h4;
      2: return 32'h8;
      3: return 32'hC;
      4: return 32'h10;
      5: return 32'h6;
      6: return {$urandom_range(0, 3), 2'b00};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int          n;

    #12;
    chk("rst_regs", regs_o, 128'h0);
    chk("rst_awready", awready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rdata", rdata, 0);
    #11 arst_n = 1'b1;
    #1 chk("rel_arready", arready, 0);
    @(posedge clk); #1;

    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, r);
    chk("t1_bresp", r, 2'b00);
    chk("t1_reg1", regs_o[63:32], 32'hDEADBEEF);
    do_read(32'h4, 0, d, r);
    chk("t1_rdata", d, 32'hDEADBEEF);
    chk("t1_rresp", r, 2'b00);

    fork
      do_write(32'h8, 32'h12345678, 4'hF, 3, 0, 0, r);
      begin
        @(negedge clk); @(negedge clk);
        chk("t2_wready_held", wready, 0);
      end
    join
    chk("t2_bresp", r, 2'b00);
    do_read(32'h8, 1, d, r);
    chk("t2_rdata", d, 32'h12345678);

    do_write(32'h0, 32'hFFFFFFFF, 4'hF, 0, 2, 0, r);
    do_write(32'h0, 32'h000000AA, 4'h1, 1, 0, 0, r);
    chk("t3_reg0", regs_o[31:0], 32'hFFFFFFAA);

    do_write(32'h10, 32'h55555555, 4'hF, 0, 0, 0, r);
    chk("t4_bresp_oob", r, 2'b10);
    do_write(32'h6, 32'h66666666, 4'hF, 0, 0, 1, r);
    chk("t4_bresp_mis", r, 2'b10);
    chk("t4_regs", regs_o, 128'h00000000_12345678_DEADBEEF_FFFFFFAA);
    do_read(32'h10, 0, d, r);
    chk("t4_rresp", r, 2'b10);
    chk("t4_rdata", d, 32'h0);

    fork
      do_write(32'hC, 32'hCAFEF00D, 4'hF, 0, 0, 5, r);
      begin
        n = 0;
        while (!bvalid && n < 16) begin @(negedge clk); n++; end
        repeat (5) begin
          chk("t5_bvalid", bvalid, 1);
          chk("t5_bresp", bresp, 2'b00);
          chk("t5_awready", awready, 0);
          chk("t5_wready", wready, 0);
          @(negedge clk);
        end
      end
    join
    chk("t5_awready_after", awready, 1);
    chk("t5_reg3", regs_o[127:96], 32'hCAFEF00D);

    fork
      begin
        repeat (60) begin
          do_write(rand_addr(), $urandom, 4'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), r);
        end
      end
      begin
        logic [31:0] rd_d;
        logic [1:0]  rd_r;
        repeat (60) begin
          do_read(rand_addr(), $urandom_range(0, 3), rd_d, rd_r);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
      end
    join

    awaddr = 32'h0; wdata = 32'h0BADF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h4; arvalid = 1'b1;
    @(negedge clk);
    chk("t6_ready_aw", awready, 1);
    chk("t6_ready_ar", arready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("t6_bvalid_pre", bvalid, 1);
    chk("t6_rvalid_pre", rvalid, 1);
    #2 arst_n = 1'b0;
    #1;
    chk("t6_bvalid_rst", bvalid, 0);
    chk("t6_rvalid_rst", rvalid, 0);
    chk("t6_regs_rst", regs_o, 128'h0);
    chk("t6_awready_rst", awready, 0);
    repeat (2) @(negedge clk);
    #2 arst_n = 1'b1;
    #1;
    chk("t6_awready_rel", awready, 0);
    chk("t6_wready_rel", wready, 0);
    chk("t6_arready_rel", arready, 0);
    @(negedge clk);
    chk("t6_awready_up", awready, 1);
    chk("t6_wready_up", wready, 1);
    chk("t6_arready_up", arready, 1);
    repeat (3) @(negedge clk);
    chk("t6_no_b", bvalid, 0);
    chk("t6_no_r", rvalid, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_axil_regfile.md
Name: vga_axil_regfile

Overview:
- AXI4-Lite slave (responder) that holds a small bank of word-wide control/status registers for the VGA core, e.g. timing and framebuffer base.
- Accepts single-beat writes and reads from the AXI-Lite master on the shared vga_axil_if signal set.
- Returns OKAY or SLVERR per transaction.
- Exposes the register contents as a flat output bus to the video datapath.

Parameters:
- ADDR_W, 32, width of awaddr/araddr (axil_addr_t).
- DATA_W, 32, width of wdata/rdata (axil_data_t); must be 32.
- REG_NUM, 4, number of 32-bit registers; must be a power of two, 1..16.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- arst_n  in  1  asynchronous reset, active low.
- awaddr  in  ADDR_W  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte write strobes.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response (axil_resp_e: OKAY=0, SLVERR=2).
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  ADDR_W  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_W  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- regs_o  out  REG_NUM*DATA_W  register contents; reg i at bits [i*32 +: 32].

Behaviour:
- Reset (arst_n low, asynchronous):
  - All registers clear to 0.
  - bvalid=0, rvalid=0, bresp=OKAY, rresp=OKAY, rdata=0.
  - awready=0, wready=0, arready=0.
  - The ready signals are gated by an "alive" flop that sets on the first clk edge after arst_n deasserts, so no handshake can complete during reset or on the release edge.
- Address decode:
  - Valid iff addr[1:0]==0 and addr < REG_NUM*4; index = addr[2 +: log2(REG_NUM)].
  - Otherwise decode error: response SLVERR, no register modified, rdata=0.
- Write path, with AW and W captured independently into one-entry holding buffers:
  - awready = alive & !aw_held & !bvalid.
  - wready = alive & !w_held & !bvalid.
  - AW and W may arrive in the same cycle or in either order with any gap; neither handshake waits on the other.
  - In the cycle after both buffers are full, the write commits and bvalid rises:
    - valid decode: each byte lane with wstrb=1 updates; bresp=OKAY.
    - error decode: bresp=SLVERR.
  - Both buffers clear on commit.
  - bvalid and bresp hold until bready=1; they drop on the cycle after the B handshake.
  - No new AW/W is accepted while bvalid=1, so at most one write is outstanding.
  - wstrb=0 on a valid address: OKAY, register unchanged.
- Read path:
  - arready = alive & !rvalid.
  - On an AR handshake, next cycle: rvalid=1, rdata = register (or 0 on error), rresp = OKAY or SLVERR.
  - rdata and rresp hold stable until rready=1; rvalid drops the cycle after the handshake.
  - Throughput: one read per 2 cycles when rready is tied high.
- Simultaneous read and write:
  - The channels are independent.
  - A read accepted in the same cycle a write commits to the same register returns the pre-write value.
- regs_o is the direct flop output; it updates the cycle after the commit cycle.
- Mid-transaction reset:
  - Outstanding B/R responses and held AW/W entries are discarded.
  - No response is issued after reset releases.
- Outputs depend on no combinational path from any *valid/*ready input to any output; all outputs are flop-driven.

Test Plan:
- Write addr 0x4, data 0xDEADBEEF, wstrb 0xF, AW and W in the same cycle, bready=1 -> one B beat, bresp=OKAY; regs_o[63:32]=0xDEADBEEF; read 0x4 returns rdata=0xDEADBEEF, rresp=OKAY.
- Send W (data 0x12345678) 3 cycles before AW (addr 0x8), then read 0x8 -> bresp=OKAY; read returns 0x12345678; wready low while W is held.
- Write 0xFFFFFFFF to 0x0, then write 0x000000AA to 0x0 with wstrb 0x1 -> reg0=0xFFFFFFAA.
- Write addr 0x10 (REG_NUM=4), then write addr 0x6 (misaligned), then read 0x10 -> both writes return SLVERR; regs_o unchanged; read returns rresp=SLVERR, rdata=0.
- Hold bready=0 for 5 cycles after a write to 0xC -> bvalid and bresp stay stable; awready/wready stay 0; a second AW is not accepted until the cycle after the B handshake.
- Assert arst_n=0 while bvalid=1 and rvalid=1, then release -> bvalid=0, rvalid=0, regs_o=0 immediately; readys=0 until the first clk edge after release, then awready=wready=arready=1.
